mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the fetch (IF) stage and the memory (MEM) stage of the riscv pipeline.
- Arbitrates requests from the two ports and sequences exactly one memory access at a time against a fixed-latency memory.
- Returns the response to the requester with a valid pulse.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and defaults for the IF/DM memory port arbiter
package riscv_mem_pkg;

  localparam int MEM_LAT_DEFAULT    = 2;
  localparam int STARVE_MAX_DEFAULT = 3;
  localparam int CNT_W              = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch port, data port and memory port signal bundle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection, data port first unless fetch is starved
module mem_arb_pick
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output port_e            winner,
  output logic             valid
);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  always_comb begin
    valid  = if_req | dm_req;
    winner = PORT_IF;
    if (dm_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
      winner = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - sequences one fixed-latency access at a time for the fetch and data ports
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  localparam int               BE_W       = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e           state;
  port_e            owner;
  port_e            pick_id;
  logic             owner_we;
  logic             pick_valid;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req     (bus.if_req),
    .dm_req     (bus.dm_req),
    .starve_cnt (starve_cnt),
    .winner     (pick_id),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= PORT_IF;
      owner_we      <= 1'b0;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      busy          <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.dm_gnt    <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.dm_rdata  <= {DATA_W{1'b0}};
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= {BE_W{1'b0}};
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.dm_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      case (state)
        // RESP arbitrates like IDLE so back-to-back accesses lose no cycle
        IDLE, RESP: begin
          if (pick_valid) begin
            state      <= ISSUE;
            owner      <= pick_id;
            busy       <= 1'b1;
            bus.mem_en <= 1'b1;
            if (pick_id == PORT_DM) begin
              bus.dm_gnt    <= 1'b1;
              bus.mem_we    <= bus.dm_we;
              bus.mem_be    <= bus.dm_be;
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_wdata;
              owner_we      <= bus.dm_we;
            end else begin
              bus.if_gnt    <= 1'b1;
              bus.mem_be    <= {BE_W{1'b1}};
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= {DATA_W{1'b0}};
              owner_we      <= 1'b0;
            end
            if ((pick_id == PORT_DM) && bus.if_req) begin
              starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + CNT_W'(1);
            end else begin
              starve_cnt <= '0;
            end
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= RESP;
            if (owner == PORT_DM) begin
              bus.dm_rvalid <= 1'b1;
              bus.dm_rdata  <= owner_we ? {DATA_W{1'b0}} : bus.mem_rdata;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 3;
  localparam int NR   = 500;
  localparam int NC   = NR + 16;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  logic clk;
  logic reset;
  logic busy;
  int   n_pass;
  int   n_total;

  vec_t vecs [0:5];
  int   exp_order [0:7];
  int   got [0:7];
  int   ng;

  logic        e_ifg [0:NC-1];
  logic        e_dmg [0:NC-1];
  logic        e_ifv [0:NC-1];
  logic        e_dmv [0:NC-1];
  logic        e_busy [0:NC-1];
  logic        e_we [0:NC-1];
  logic [31:0] e_addr [0:NC-1];
  logic [31:0] e_be [0:NC-1];
  logic [31:0] e_wd [0:NC-1];
  logic [31:0] e_rd [0:NC-1];
  int   next_arb;
  int   starve;
  logic if_pend;
  logic dm_pend;
  logic pick_dm;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'd3;
  endfunction

  // Fixed-latency memory: data for an access appears LAT cycles after its mem_en cycle
  logic [DW-1:0] mem_pipe [0:LAT-1];
  always @(posedge clk) begin
    mem_pipe[0] <= bus.mem_en ? word_at(bus.mem_addr) : 32'hBAD0_BAD0;
    for (int k = 1; k < LAT; k++) mem_pipe[k] <= mem_pipe[k-1];
  end
  assign bus.mem_rdata = mem_pipe[LAT-1];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_be    = '0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_if_gnt"}, bus.if_gnt, 1'b0);
    chk1({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    chk1({tag, "_dm_gnt"}, bus.dm_gnt, 1'b0);
    chk1({tag, "_dm_rvalid"}, bus.dm_rvalid, 1'b0);
    chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'h0);
    chk1({tag, "_mem_en"}, bus.mem_en, 1'b0);
    chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk1({tag, "_drained"}, busy, 1'b0);
    step();
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_dm) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = v.we;
      bus.dm_be    = v.be;
      bus.dm_addr  = v.addr;
      bus.dm_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    step();
    chk1("vec_if_gnt", bus.if_gnt, !v.is_dm);
    chk1("vec_dm_gnt", bus.dm_gnt, v.is_dm);
    chk1("vec_mem_en", bus.mem_en, 1'b1);
    chk1("vec_mem_we", bus.mem_we, v.we);
    chk("vec_mem_addr", bus.mem_addr, v.addr);
    if (v.is_dm) begin
      chk("vec_mem_be", 32'(bus.mem_be), 32'(v.be));
      chk("vec_mem_wdata", bus.mem_wdata, v.wdata);
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    for (int c = 2; c <= LAT + 1; c++) begin
      step();
      chk1("vec_wait_mem_en", bus.mem_en, 1'b0);
      chk1("vec_wait_mem_we", bus.mem_we, 1'b0);
      chk1("vec_wait_if_rvalid", bus.if_rvalid, 1'b0);
      chk1("vec_wait_dm_rvalid", bus.dm_rvalid, 1'b0);
      chk1("vec_wait_busy", busy, 1'b1);
    end
    step();
    chk1("vec_if_rvalid", bus.if_rvalid, !v.is_dm);
    chk1("vec_dm_rvalid", bus.dm_rvalid, v.is_dm);
    chk("vec_rdata", v.is_dm ? bus.dm_rdata : bus.if_rdata, v.rdata);
    step();
    chk1("vec_idle_busy", busy, 1'b0);
    chk1("vec_idle_rvalid", bus.if_rvalid | bus.dm_rvalid, 1'b0);
    chk("vec_mem_addr_held", bus.mem_addr, v.addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0000_0000, 32'h0000_0203};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 4'h1, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF3};
    exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};

    reset = 1'b1;
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.dm_req  = 1'b1;
    bus.if_addr = 32'h40;
    bus.dm_addr = 32'h80;
    repeat (3) step();
    chk_all_zero("rst_hold");
    idle_inputs();
    step();
    reset = 1'b0;
    step();
    chk1("idle_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Asynchronous reset while the fetch is waiting on memory
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h60;
    step();
    chk1("rw_if_gnt", bus.if_gnt, 1'b1);
    bus.if_req = 1'b0;
    step();
    chk1("rw_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_wait");
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk1("rst_no_if_rvalid", bus.if_rvalid, 1'b0);
      chk1("rst_no_busy", busy, 1'b0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
    end

    // Simultaneous requests: data first, fetch in data's response cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_be   = 4'hF;
    bus.dm_addr = 32'h300;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk1("sim_dm_gnt", bus.dm_gnt, c == 1);
      chk1("sim_if_gnt", bus.if_gnt, c == 5);
      chk1("sim_dm_rvalid", bus.dm_rvalid, c == 4);
      chk1("sim_if_rvalid", bus.if_rvalid, c == 8);
      chk1("sim_busy", busy, c <= 8);
      if (c == 4) chk("sim_dm_rdata", bus.dm_rdata, 32'h303);
      if (c == 5) chk("sim_if_addr", bus.mem_addr, 32'h20);
      if (c == 8) chk("sim_if_rdata", bus.if_rdata, 32'h23);
      if (c == 1) bus.dm_req = 1'b0;
      if (c == 5) bus.if_req = 1'b0;
    end
    drain("sim");

    // Starvation: both held, fetch must get every fourth grant
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h600;
    ng = 0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      step();
      if (bus.dm_gnt || bus.if_gnt) begin
        got[ng] = bus.dm_gnt ? 1 : 0;
        ng++;
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    chk("starve_grant_count", ng, 8);
    for (int i = 0; i < ng; i++) chk("starve_order", got[i], exp_order[i]);
    drain("starve");

    // Withdrawal: a data request that vanishes before arbitration never reaches memory
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk1("wd_dm_gnt", bus.dm_gnt, 1'b0);
      chk1("wd_mem_en", bus.mem_en, c == 1);
      chk1("wd_if_rvalid", bus.if_rvalid, c == 4);
      chk1("wd_busy", busy, c <= 4);
      if (c == 1) bus.if_req = 1'b0;
      if (c == 2) begin
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h500;
        bus.dm_wdata = 32'h55;
      end
      if (c == 3) bus.dm_req = 1'b0;
    end
    idle_inputs();
    drain("wd");

    // Random traffic against a transaction-level model of arbitration and timing
    for (int i = 0; i < NC; i++) begin
      e_ifg[i] = 1'b0; e_dmg[i] = 1'b0; e_ifv[i] = 1'b0; e_dmv[i] = 1'b0;
      e_busy[i] = 1'b0; e_we[i] = 1'b0;
      e_addr[i] = '0; e_be[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
    end
    next_arb = 0;
    starve   = 0;
    if_pend  = 1'b0;
    dm_pend  = 1'b0;
    for (int c = 0; c < NC; c++) begin
      chk1("rnd_if_gnt", bus.if_gnt, e_ifg[c]);
      chk1("rnd_dm_gnt", bus.dm_gnt, e_dmg[c]);
      chk1("rnd_mem_en", bus.mem_en, e_ifg[c] | e_dmg[c]);
      chk1("rnd_mem_we", bus.mem_we, e_we[c]);
      chk1("rnd_if_rvalid", bus.if_rvalid, e_ifv[c]);
      chk1("rnd_dm_rvalid", bus.dm_rvalid, e_dmv[c]);
      chk1("rnd_busy", busy, e_busy[c]);
      if (e_ifg[c] || e_dmg[c]) chk("rnd_mem_addr", bus.mem_addr, e_addr[c]);
      if (e_dmg[c]) begin
        chk("rnd_mem_be", 32'(bus.mem_be), e_be[c]);
        chk("rnd_mem_wdata", bus.mem_wdata, e_wd[c]);
      end
      if (e_ifv[c]) chk("rnd_if_rdata", bus.if_rdata, e_rd[c]);
      if (e_dmv[c]) chk("rnd_dm_rdata", bus.dm_rdata, e_rd[c]);

      if (e_ifg[c]) if_pend = 1'b0;
      if (e_dmg[c]) dm_pend = 1'b0;
      if (c < NR) begin
        if (!if_pend) begin
          if ($urandom_range(0, 2) == 0) begin
            if_pend     = 1'b1;
            bus.if_addr = $urandom() & 32'hFFFF_FFFC;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          if_pend = 1'b0;
        end
        if (!dm_pend) begin
          if ($urandom_range(0, 2) == 0) begin
            dm_pend      = 1'b1;
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_be    = 4'($urandom());
            bus.dm_addr  = $urandom() & 32'hFFFF_FFFC;
            bus.dm_wdata = $urandom();
          end
        end else if ($urandom_range(0, 9) == 0) begin
          dm_pend = 1'b0;
        end
      end else begin
        if_pend = 1'b0;
        dm_pend = 1'b0;
      end
      bus.if_req = if_pend;
      bus.dm_req = dm_pend;

      if (c >= next_arb) begin
        if (if_pend || dm_pend) begin
          pick_dm = dm_pend && !(if_pend && starve == SMAX);
          starve  = (pick_dm && if_pend) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
          if (pick_dm) begin
            e_dmg[c+1]  = 1'b1;
            e_we[c+1]   = bus.dm_we;
            e_addr[c+1] = bus.dm_addr;
            e_be[c+1]   = 32'(bus.dm_be);
            e_wd[c+1]   = bus.dm_wdata;
            e_dmv[c+LAT+2] = 1'b1;
            e_rd[c+LAT+2]  = bus.dm_we ? 32'h0 : word_at(bus.dm_addr);
          end else begin
            e_ifg[c+1]  = 1'b1;
            e_addr[c+1] = bus.if_addr;
            e_ifv[c+LAT+2] = 1'b1;
            e_rd[c+LAT+2]  = word_at(bus.if_addr);
          end
          for (int k = c + 1; k <= c + LAT + 2; k++) e_busy[k] = 1'b1;
          next_arb = c + LAT + 2;
        end else begin
          starve = 0;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
